// File: rtl/rect_flip_pkg.sv
// Shared types and helpers for the rectangle-flip engine.
// Build option RECT_FLIP_DEGEN_CHECK_EN is consumed by rect_flip_engine.
package rect_flip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column-major layout with cell (0,0) in the MSB of the flattened matrix.
    function automatic int cell_idx(input int r, input int c, input int rows, input int cols);
        return rows * cols - 1 - (c * rows + r);
    endfunction

endpackage

// File: rtl/rect_flip_if.sv
// Load / command / status bundle between the search controller and rect_flip_engine.
// master drives loads, commands and pause; slave is the engine.
interface rect_flip_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic             load_valid;
    logic             load_ready;
    logic [N-1:0]     load_data;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [RW-1:0]    cmd_r1;
    logic [RW-1:0]    cmd_r2;
    logic [CW-1:0]    cmd_c1;
    logic [CW-1:0]    cmd_c2;
    logic             pause;
    logic [N-1:0]     m_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] flip_cnt;
    logic             err;

    modport master (
        output load_valid, load_data, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, pause,
        input  load_ready, cmd_ready, m_out, busy, done, flip_cnt, err
    );

    modport slave (
        input  load_valid, load_data, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2, pause,
        output load_ready, cmd_ready, m_out, busy, done, flip_cnt, err
    );

endinterface

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full, pop is ignored when empty.
// The head is read combinationally so a pop and its apply land on the same edge.
module rect_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rect_flip_engine.sv
// Queued rectangle-flip engine: buffers (r1,r2,c1,c2) commands and XOR-toggles the four corners.
// Define RECT_FLIP_DEGEN_CHECK_EN to reject degenerate commands with an err pulse.
module rect_flip_engine
    import rect_flip_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    rect_flip_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = 2 * RW + 2 * CW;
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
    } cmd_t;

    state_t           state_reg;
    state_t           state_next;
    logic [N-1:0]     m_reg;
    logic [CNT_W-1:0] cnt_reg;
    cmd_t             cmd_in;
    cmd_t             head;
    logic             full;
    logic             empty;
    logic [AW:0]      fifo_count;
    logic             push;
    logic             pop;
    logic             load_fire;
    logic             load_ready_int;
    logic             busy_int;
    logic             done_int;
    logic             in_range;
    logic             accept;
    logic [N-1:0]     mask;

    assign cmd_in    = '{r1: bus.cmd_r1, r2: bus.cmd_r2, c1: bus.cmd_c1, c2: bus.cmd_c2};
    assign push      = bus.cmd_valid && !full;
    assign load_fire = bus.load_valid && load_ready_int;

    rect_cmd_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!empty) state_next = RUN;
            // Draining to empty with a push on the same edge keeps the run going.
            RUN:  if (pop && fifo_count == (AW+1)'(1) && !push) state_next = DONE;
            DONE: state_next = empty ? IDLE : RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop            = (state_reg == RUN) && !bus.pause && !empty;
        done_int       = (state_reg == DONE);
        busy_int       = (state_reg != IDLE) || !empty;
        load_ready_int = (state_reg == IDLE) && empty;
    end

    // A cell toggles iff it is hit an odd number of times by the four corners,
    // i.e. exactly one row selector and exactly one column selector match.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            localparam int BIT = cell_idx(gi, gj, ROWS, COLS);
            assign mask[BIT] = ((head.r1 == RW'(gi)) ^ (head.r2 == RW'(gi)))
                             & ((head.c1 == CW'(gj)) ^ (head.c2 == CW'(gj)));
        end
    end

    assign in_range = (int'(head.r1) < ROWS) && (int'(head.r2) < ROWS)
                   && (int'(head.c1) < COLS) && (int'(head.c2) < COLS);

`ifdef RECT_FLIP_DEGEN_CHECK_EN
    logic degen;
    logic err_reg;

    assign degen  = (head.r1 == head.r2) || (head.c1 == head.c2);
    assign accept = in_range && !degen;

    always_ff @(posedge clk) begin
        if (rst) err_reg <= 1'b0;
        else     err_reg <= pop && !accept;
    end

    assign bus.err = err_reg;
`else
    assign accept  = in_range;
    assign bus.err = 1'b0;
`endif

    // Loads are only possible in IDLE with an empty FIFO, so they never meet a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            cnt_reg <= '0;
        end else if (load_fire) begin
            m_reg <= bus.load_data;
        end else if (pop && accept) begin
            m_reg <= m_reg ^ mask;
            if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bus.m_out      = m_reg;
    assign bus.flip_cnt   = cnt_reg;
    assign bus.busy       = busy_int;
    assign bus.done       = done_int;
    assign bus.load_ready = load_ready_int;
    assign bus.cmd_ready  = !full;

endmodule

// File: tb/tb_rect_flip_engine.sv
// Self-checking bench for rect_flip_engine (4x4, DEPTH 4): vector table, corner sequences,
// randomized traffic against a 2-D array model, and a CNT_W=4 saturation instance.
module tb_rect_flip_engine;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int N     = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rect_flip_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(16)) bus ();
    rect_flip_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(4))  sbus ();

    rect_flip_engine #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rect_flip_engine #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    int n_cmp    = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int cnt_exp  = 0;
    logic [N-1:0] model_m = '0;

    typedef struct {
        logic [N-1:0] start;
        int           r1, r2, c1, c2;
        logic [N-1:0] exp_m;
        bit           degen;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        err_seen += int'(bus.err);
    endtask

    // Reference: unpack to a 2-D grid, toggle the four corners, repack.
    function automatic logic [N-1:0] model_flip(input logic [N-1:0] m, input int r1, input int r2,
                                                input int c1, input int c2);
        bit g [ROWS][COLS];
        logic [N-1:0] res;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                g[r][c] = m[N-1-(c*ROWS+r)];
        g[r1][c1] = !g[r1][c1];
        g[r1][c2] = !g[r1][c2];
        g[r2][c1] = !g[r2][c1];
        g[r2][c2] = !g[r2][c2];
        res = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                res[N-1-(c*ROWS+r)] = g[r][c];
        return res;
    endfunction

    function automatic bit rejected(input int r1, input int r2, input int c1, input int c2);
`ifdef RECT_FLIP_DEGEN_CHECK_EN
        return (r1 == r2) || (c1 == c2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_cmd(input int r1, input int r2, input int c1, input int c2);
        bus.cmd_valid = 1'b1;
        bus.cmd_r1 = 2'(r1);
        bus.cmd_r2 = 2'(r2);
        bus.cmd_c1 = 2'(c1);
        bus.cmd_c2 = 2'(c2);
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (bus.busy && k < max_cycles) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   cr1 [5];
        int   cr2 [5];
        int   cc1 [5];
        int   cc2 [5];
        bit   exp_err;
        int   err_base;
        int   exp_rej;
        int   acc_cnt;
        int   guard;

        vecs[0] = '{start: 16'h0000, r1: 0, r2: 1, c1: 0, c2: 1, exp_m: 16'hCC00, degen: 1'b0};
        vecs[1] = '{start: 16'hCC00, r1: 0, r2: 1, c1: 0, c2: 1, exp_m: 16'h0000, degen: 1'b0};
        vecs[2] = '{start: 16'h0000, r1: 2, r2: 2, c1: 0, c2: 3, exp_m: 16'h0000, degen: 1'b1};
        vecs[3] = '{start: 16'hFFFF, r1: 3, r2: 0, c1: 3, c2: 0, exp_m: 16'h6FF6, degen: 1'b0};
        vecs[4] = '{start: 16'h1234, r1: 1, r2: 2, c1: 2, c2: 1, exp_m: 16'h1454, degen: 1'b0};
        vecs[5] = '{start: 16'hA5A5, r1: 0, r2: 3, c1: 1, c2: 1, exp_m: 16'hA5A5, degen: 1'b1};

        cr1 = '{0, 1, 2, 0, 0};
        cr2 = '{1, 2, 3, 3, 1};
        cc1 = '{0, 1, 2, 0, 2};
        cc2 = '{1, 2, 3, 3, 3};

        bus.load_valid = 1'b0; bus.load_data = '0; bus.pause = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_r1 = '0; bus.cmd_r2 = '0; bus.cmd_c1 = '0; bus.cmd_c2 = '0;
        sbus.load_valid = 1'b0; sbus.load_data = '0; sbus.pause = 1'b0;
        sbus.cmd_valid = 1'b0; sbus.cmd_r1 = '0; sbus.cmd_r2 = '0; sbus.cmd_c1 = '0; sbus.cmd_c2 = '0;

        // ---- reset state
        rst = 1'b1;
        tick(); tick();
        check("rst_m_out",      32'(bus.m_out),      32'd0);
        check("rst_flip_cnt",   32'(bus.flip_cnt),   32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd1);
        check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        rst = 1'b0;
        tick();

        // ---- table: load + one command accepted together, result two edges later
        for (int v = 0; v < 6; v++) begin
            exp_err = vecs[v].degen && rejected(vecs[v].r1, vecs[v].r2, vecs[v].c1, vecs[v].c2);
            check("vec_load_ready", 32'(bus.load_ready), 32'd1);
            bus.load_valid = 1'b1;
            bus.load_data  = vecs[v].start;
            drive_cmd(vecs[v].r1, vecs[v].r2, vecs[v].c1, vecs[v].c2);
            tick();
            bus.load_valid = 1'b0;
            bus.cmd_valid  = 1'b0;
            check("vec_loaded", 32'(bus.m_out), 32'(vecs[v].start));
            tick();
            check("vec_latency_hold", 32'(bus.m_out), 32'(vecs[v].start));
            check("vec_busy", 32'(bus.busy), 32'd1);
            tick();
            if (!exp_err) cnt_exp++;
            check("vec_m_out",    32'(bus.m_out),    32'(vecs[v].exp_m));
            check("vec_flip_cnt", 32'(bus.flip_cnt), 32'(cnt_exp));
            check("vec_done",     32'(bus.done),     32'd1);
            check("vec_err",      32'(bus.err),      32'(exp_err));
            tick();
            check("vec_done_clear", 32'(bus.done), 32'd0);
            check("vec_err_clear",  32'(bus.err),  32'd0);
            check("vec_idle",       32'(bus.busy), 32'd0);
            model_m = vecs[v].exp_m;
            $display("vec %0d: start=%h cmd=(%0d,%0d,%0d,%0d) m_out=%h cnt=%0d err=%0b",
                     v, vecs[v].start, vecs[v].r1, vecs[v].r2, vecs[v].c1, vecs[v].c2,
                     bus.m_out, bus.flip_cnt, exp_err);
        end

        // ---- paused fill: 5 offers, only DEPTH accepted, then drain back-to-back
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(cr1[i], cr2[i], cc1[i], cc2[i]);
            check("fill_cmd_ready", 32'(bus.cmd_ready), 32'(i < DEPTH));
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("fill_load_ready", 32'(bus.load_ready), 32'd0);
        check("fill_busy",       32'(bus.busy),       32'd1);
        tick();
        check("fill_paused_hold", 32'(bus.m_out), 32'(model_m));
        bus.pause = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            tick();
            model_m = model_flip(model_m, cr1[j], cr2[j], cc1[j], cc2[j]);
            cnt_exp++;
            check("drain_m_out",     32'(bus.m_out),     32'(model_m));
            check("drain_done",      32'(bus.done),      32'(j == DEPTH - 1));
            check("drain_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            $display("drain %0d: m_out=%h done=%0b", j, bus.m_out, bus.done);
        end
        tick();
        check("drain_done_clear", 32'(bus.done),       32'd0);
        check("drain_idle",       32'(bus.busy),       32'd0);
        check("drain_load_ready", 32'(bus.load_ready), 32'd1);
        check("drain_flip_cnt",   32'(bus.flip_cnt),   32'(cnt_exp));

        // ---- reset mid-run discards queued commands
        drive_cmd(0, 1, 0, 1); tick();
        drive_cmd(1, 2, 1, 2); tick();
        drive_cmd(2, 3, 2, 3); tick();
        check("midrst_first_apply", 32'(bus.m_out), 32'(model_flip(model_m, 0, 1, 0, 1)));
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_m_out",      32'(bus.m_out),      32'd0);
        check("midrst_flip_cnt",   32'(bus.flip_cnt),   32'd0);
        check("midrst_busy",       32'(bus.busy),       32'd0);
        check("midrst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        check("midrst_load_ready", 32'(bus.load_ready), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        check("midrst_no_apply", 32'(bus.m_out),    32'd0);
        check("midrst_cnt_hold", 32'(bus.flip_cnt), 32'd0);
        $display("midrst: m_out=%h cnt=%0d busy=%0b", bus.m_out, bus.flip_cnt, bus.busy);
        model_m = '0;
        cnt_exp = 0;

        // ---- randomized traffic; XOR is order-free so the drained matrix is the fold of all accepts
        err_base = err_seen;
        exp_rej  = 0;
        for (int rnd = 0; rnd < 40; rnd++) begin
            int ncmd;
            int pushed;
            if ($urandom_range(0, 2) == 0) begin
                logic [N-1:0] ld;
                ld = N'($urandom);
                check("rand_load_ready", 32'(bus.load_ready), 32'd1);
                bus.load_valid = 1'b1;
                bus.load_data  = ld;
                tick();
                bus.load_valid = 1'b0;
                model_m = ld;
            end
            ncmd   = int'($urandom_range(1, 8));
            pushed = 0;
            guard  = 0;
            while (pushed < ncmd && guard < 200) begin
                int  r1, r2, c1, c2;
                bit  acc;
                r1 = int'($urandom_range(0, ROWS - 1));
                r2 = int'($urandom_range(0, ROWS - 1));
                c1 = int'($urandom_range(0, COLS - 1));
                c2 = int'($urandom_range(0, COLS - 1));
                bus.pause = ($urandom_range(0, 3) == 0);
                acc = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    drive_cmd(r1, r2, c1, c2);
                    acc = bus.cmd_ready;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
                tick();
                if (acc) begin
                    pushed++;
                    if (rejected(r1, r2, c1, c2)) begin
                        exp_rej++;
                    end else begin
                        model_m = model_flip(model_m, r1, r2, c1, c2);
                        cnt_exp++;
                    end
                end
                guard++;
            end
            check("rand_push_timeout", 32'(pushed), 32'(ncmd));
            bus.cmd_valid = 1'b0;
            bus.pause     = 1'b0;
            wait_idle(60);
            check("rand_m_out",    32'(bus.m_out),    32'(model_m));
            check("rand_flip_cnt", 32'(bus.flip_cnt), 32'(cnt_exp));
            $display("rand %0d: cmds=%0d m_out=%h cnt=%0d", rnd, ncmd, bus.m_out, bus.flip_cnt);
        end
        check("rand_err_pulses", 32'(err_seen - err_base), 32'(exp_rej));

        // ---- CNT_W=4 instance: counter saturates at 4'hF
        acc_cnt = 0;
        guard   = 0;
        while (acc_cnt < 17 && guard < 200) begin
            bit acc;
            sbus.cmd_valid = 1'b1;
            sbus.cmd_r1 = 2'd0; sbus.cmd_r2 = 2'd1; sbus.cmd_c1 = 2'd0; sbus.cmd_c2 = 2'd1;
            acc = sbus.cmd_ready;
            tick();
            if (acc) acc_cnt++;
            guard++;
            if (acc_cnt == 15) begin
                sbus.cmd_valid = 1'b0;
                for (int k = 0; k < 40 && sbus.busy; k++) tick();
                check("sat_cnt_15", 32'(sbus.flip_cnt), 32'hF);
                acc_cnt++;
                acc_cnt--;
                if (acc_cnt == 15) acc_cnt = 15;
            end
        end
        sbus.cmd_valid = 1'b0;
        for (int k = 0; k < 40 && sbus.busy; k++) tick();
        check("sat_busy",     32'(sbus.busy),     32'd0);
        check("sat_cnt_17",   32'(sbus.flip_cnt), 32'hF);
        check("sat_m_out",    32'(sbus.m_out),    32'(model_flip('0, 0, 1, 0, 1)));
        $display("sat: flips=%0d flip_cnt=%h m_out=%h", acc_cnt, sbus.flip_cnt, sbus.m_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
